// File: rtl/fill_r_fifo.sv
// Fill-path R-channel receiver: assembles BEATS-beat bursts into one line tagged with the oldest queued TID.
// Latency: line presented the cycle after its last beat is accepted; at least one bubble between lines.
// Backpressure: rready_o drops while a line waits in S_OUT; fill outputs hold until fill_ready_i.
module fill_r_fifo #(
  parameter int                  DATA_WIDTH = 64,
  parameter int                  ID_WIDTH   = 4,
  parameter logic [ID_WIDTH-1:0] ID         = '0,
  parameter int                  TID_WIDTH  = 8,
  parameter int                  BEATS      = 4,
  parameter int                  TID_DEPTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ID_WIDTH-1:0]         rid_i,
  input  logic [DATA_WIDTH-1:0]       rdata_i,
  input  logic [1:0]                  rresp_i,
  input  logic                        rlast_i,
  input  logic                        rvalid_i,
  output logic                        rready_o,
  input  logic                        tid_wren_i,
  input  logic [TID_WIDTH-1:0]        tid_i,
  output logic                        tid_full_o,
  output logic                        fill_valid_o,
  input  logic                        fill_ready_i,
  output logic [TID_WIDTH-1:0]        fill_tid_o,
  output logic [DATA_WIDTH*BEATS-1:0] fill_data_o,
  output logic                        fill_err_o
);

  localparam int               CW        = $clog2(BEATS);
  localparam int               PW        = $clog2(TID_DEPTH);
  localparam int               LW        = DATA_WIDTH * BEATS;
  localparam logic [CW-1:0]    LAST_BEAT = CW'(BEATS - 1);
  localparam logic [PW:0]      FULL_CNT  = TID_DEPTH[PW:0];

  typedef enum logic [1:0] {S_COLLECT, S_DRAIN, S_OUT} state_t;

  // TID queue storage and bookkeeping
  logic [TID_WIDTH-1:0] tid_mem_q [TID_DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [PW:0]          cnt_q;
  logic                 push, pop;

  // Line assembly state
  state_t               state_q, state_d;
  logic [CW-1:0]        beat_cnt_q, beat_cnt_d;
  logic                 err_q, err_d;
  logic [LW-1:0]        line_q, line_d;

  assign tid_full_o = (cnt_q == FULL_CNT);
  assign pop        = fill_valid_o && fill_ready_i;
  // A pop frees the head slot in the same cycle, so a push at full still lands.
  assign push       = tid_wren_i && (!tid_full_o || pop);

  // TID storage is data-only; validity is tracked by the count, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) tid_mem_q[wr_ptr_q] <= tid_i;
  end

  // TID queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Collect / drain / present sequencing; rready_o depends only on state and queue count.
  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    err_d        = err_q;
    line_d       = line_q;
    rready_o     = 1'b0;
    fill_valid_o = 1'b0;
    case (state_q)
      S_COLLECT: begin
        rready_o = (cnt_q != '0);
        if (rvalid_i && rready_o) begin
          line_d[int'(beat_cnt_q) * DATA_WIDTH +: DATA_WIDTH] = rdata_i;
          beat_cnt_d = beat_cnt_q + 1'b1;
          err_d      = err_q | (rresp_i != 2'b00) | (rid_i != ID);
          if (beat_cnt_q == LAST_BEAT) begin
            if (rlast_i) begin
              state_d = S_OUT;
            end else begin
              // Burst longer than a line: keep what we have, swallow the rest.
              err_d   = 1'b1;
              state_d = S_DRAIN;
            end
          end else if (rlast_i) begin
            // Short burst: unwritten beats remain zero.
            err_d   = 1'b1;
            state_d = S_OUT;
          end
        end
      end
      S_DRAIN: begin
        rready_o = 1'b1;
        if (rvalid_i && rlast_i) state_d = S_OUT;
      end
      S_OUT: begin
        fill_valid_o = 1'b1;
        if (fill_ready_i) begin
          line_d     = '0;
          beat_cnt_d = '0;
          err_d      = 1'b0;
          state_d    = S_COLLECT;
        end
      end
      default: state_d = S_COLLECT;
    endcase
  end

  // Assembly state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_COLLECT;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      line_q     <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
      line_q     <= line_d;
    end
  end

  assign fill_tid_o  = (state_q == S_OUT) ? tid_mem_q[rd_ptr_q] : '0;
  assign fill_err_o  = (state_q == S_OUT) && err_q;
  assign fill_data_o = line_q;

endmodule

// File: tb/tb_fill_r_fifo.sv
// Randomized bench for fill_r_fifo against a queue-based line/TID reference model.
// Inputs change just after rising edges; outputs are sampled on falling edges.
// Prints one summary line of passed/total checks.
module tb_fill_r_fifo;
  localparam int DW = 64, IW = 4, TW = 8, NB = 4, TD = 8;
  localparam logic [IW-1:0] FID = 4'h3;

  logic           clk = 1'b0;
  logic           rst;
  logic [IW-1:0]  rid_i;
  logic [DW-1:0]  rdata_i;
  logic [1:0]     rresp_i;
  logic           rlast_i, rvalid_i, rready_o;
  logic           tid_wren_i;
  logic [TW-1:0]  tid_i;
  logic           tid_full_o, fill_valid_o, fill_ready_i, fill_err_o;
  logic [TW-1:0]  fill_tid_o;
  logic [DW*NB-1:0] fill_data_o;

  fill_r_fifo #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .ID(FID), .TID_WIDTH(TW),
                .BEATS(NB), .TID_DEPTH(TD)) dut (
    .clk(clk), .rst(rst), .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i),
    .rlast_i(rlast_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
    .tid_wren_i(tid_wren_i), .tid_i(tid_i), .tid_full_o(tid_full_o),
    .fill_valid_o(fill_valid_o), .fill_ready_i(fill_ready_i),
    .fill_tid_o(fill_tid_o), .fill_data_o(fill_data_o), .fill_err_o(fill_err_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  logic [TW-1:0] tidq[$];   // reference TID queue

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic push_tid(input logic [TW-1:0] t);
    @(negedge clk);
    chk("full_pre_push", tid_full_o, tidq.size() == TD);
    @(posedge clk); #1;
    tid_wren_i = 1'b1; tid_i = t;
    @(posedge clk); #1;
    tid_wren_i = 1'b0;
    if (tidq.size() < TD) tidq.push_back(t);
  endtask

  task automatic send_beat(input logic [IW-1:0] id, input logic [DW-1:0] d,
                           input logic [1:0] rs, input logic last);
    bit acc = 0;
    rvalid_i = 1'b1; rid_i = id; rdata_i = d; rresp_i = rs; rlast_i = last;
    for (int w = 0; w < 50 && !acc; w++) begin
      @(negedge clk);
      if (rready_o) acc = 1;
      @(posedge clk); #1;
    end
    if (!acc) chk("beat_accept_timeout", 0, 1);
    rvalid_i = 1'b0; rlast_i = 1'b0;
  endtask

  task automatic send_burst(input int len, input bit directed, input int bad_resp,
                            input int bad_id, output logic [255:0] el, output logic ee);
    logic [DW-1:0] d;
    logic [1:0]    rs;
    logic [IW-1:0] id;
    el = '0;
    ee = (len != NB);
    for (int i = 0; i < len; i++) begin
      d  = directed ? DW'(17 * (i + 1)) : {$urandom, $urandom};
      rs = (i == bad_resp) ? 2'b10 : 2'b00;
      id = (i == bad_id) ? ~FID : FID;
      if (i < NB) begin
        el[i*DW +: DW] = d;
        if (rs != 2'b00 || id != FID) ee = 1'b1;
      end
      send_beat(id, d, rs, i == len - 1);
    end
  endtask

  task automatic expect_line(input string tag, input logic [255:0] el, input logic ee,
                             input int stall, input int push_v);
    logic [TW-1:0] et;
    et = (tidq.size() != 0) ? tidq[0] : '0;
    @(negedge clk);
    chk({tag, ".vld"}, fill_valid_o, 1);
    chk({tag, ".tid"}, fill_tid_o, et);
    chk({tag, ".data"}, fill_data_o, el);
    chk({tag, ".err"}, fill_err_o, ee);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk({tag, ".hold"}, {fill_valid_o, fill_tid_o, fill_err_o, rready_o}, {1'b1, et, ee, 1'b0});
      chk({tag, ".hold_data"}, fill_data_o, el);
    end
    fill_ready_i = 1'b1;
    if (push_v >= 0) begin tid_wren_i = 1'b1; tid_i = push_v[TW-1:0]; end
    @(posedge clk); #1;
    fill_ready_i = 1'b0; tid_wren_i = 1'b0;
    if (tidq.size() != 0) void'(tidq.pop_front());
    if (push_v >= 0 && tidq.size() < TD) tidq.push_back(push_v[TW-1:0]);
    @(negedge clk);
    chk({tag, ".vld_drop"}, fill_valid_o, 0);
    chk({tag, ".rready_after"}, rready_o, tidq.size() != 0);
    chk({tag, ".full_after"}, tid_full_o, tidq.size() == TD);
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [255:0] el;
    logic         ee;
    int           len, r, br, bi, np;

    rst = 1'b1; rid_i = '0; rdata_i = '0; rresp_i = '0; rlast_i = 1'b0;
    rvalid_i = 1'b0; tid_wren_i = 1'b0; tid_i = '0; fill_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst.rready", rready_o, 0);
    chk("rst.full", tid_full_o, 0);
    chk("rst.vld", fill_valid_o, 0);
    chk("rst.tid", fill_tid_o, 0);
    chk("rst.data", fill_data_o, 0);
    chk("rst.err", fill_err_o, 0);
    @(posedge clk); #1;

    // Basic line with known data
    push_tid(8'h05);
    send_burst(4, 1, -1, -1, el, ee);
    chk("basic.model_data", el, {64'h44, 64'h33, 64'h22, 64'h11});
    expect_line("basic", el, ee, 0, -1);

    // No TID queued: beats must not be accepted
    rvalid_i = 1'b1; rid_i = FID; rdata_i = 64'hdead;
    repeat (3) begin @(negedge clk); chk("notid.rready", rready_o, 0); end
    @(posedge clk); #1;
    rvalid_i = 1'b0;
    push_tid(8'h09);
    @(negedge clk);
    chk("notid.rready_after_push", rready_o, 1);
    @(posedge clk); #1;
    send_burst(4, 0, -1, -1, el, ee);
    expect_line("tid09", el, ee, 0, -1);

    // Error responses and bad IDs
    push_tid(8'h11);
    send_burst(4, 0, 2, -1, el, ee);
    expect_line("badresp", el, ee, 0, -1);
    push_tid(8'h12);
    send_burst(4, 0, -1, 1, el, ee);
    expect_line("badid", el, ee, 0, -1);

    // Short and long bursts
    push_tid(8'h13);
    send_burst(2, 1, -1, -1, el, ee);
    expect_line("short", el, ee, 0, -1);
    push_tid(8'h14);
    send_burst(6, 1, -1, -1, el, ee);
    expect_line("long", el, ee, 0, -1);

    // Fill the TID queue, overflow push, stall, push+pop at full, order check
    for (int i = 0; i < TD + 1; i++) push_tid(8'h20 + 8'(i));
    @(negedge clk);
    chk("full.flag", tid_full_o, 1);
    @(posedge clk); #1;
    send_burst(4, 0, -1, -1, el, ee);
    expect_line("full0", el, ee, 5, 8'h30);
    for (int k = 0; k < TD; k++) begin
      send_burst(4, 0, -1, -1, el, ee);
      expect_line("order", el, ee, 0, -1);
    end

    // Reset mid-burst
    push_tid(8'h40);
    send_beat(FID, 64'haaaa, 2'b00, 1'b0);
    send_beat(FID, 64'hbbbb, 2'b00, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tidq.delete();
    @(negedge clk);
    chk("mrst.outs", {rready_o, tid_full_o, fill_valid_o, fill_tid_o, fill_err_o}, 0);
    chk("mrst.data", fill_data_o, 0);
    @(posedge clk); #1;
    push_tid(8'h41);
    send_burst(4, 0, -1, -1, el, ee);
    expect_line("post_rst", el, ee, 0, -1);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      np = (tidq.size() == 0) ? 1 : ((tidq.size() < TD - 1) ? $urandom_range(0, 2) : 0);
      for (int p = 0; p < np; p++) push_tid(8'($urandom));
      r = $urandom_range(0, 7);
      len = (r < 4) ? 4 : (r == 4) ? 1 : (r == 5) ? 2 : (r == 6) ? 5 : 6;
      br = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      bi = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      send_burst(len, 0, br, bi, el, ee);
      expect_line("rand", el, ee, $urandom_range(0, 3), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
